// File: rtl/vga_sync_decoder.sv
// VGA sync receiver: rebuilds pixel coordinates and active-video from Hsync/Vsync
// and locks onto the configured timing. `VGA_SYNC_WIDTH_CHK_EN adds sync-width checks.
module vga_sync_decoder #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_hs,
  input  logic        I_vs,
  output logic [11:0] O_h_cnt,
  output logic [11:0] O_v_cnt,
  output logic        O_active,
  output logic        O_locked,
  output logic        O_frame_start,
  output logic        O_err,
  output logic [11:0] O_line_len,
  output logic [11:0] O_frame_lines
);

  localparam logic [11:0] L_CNT_MAX  = 12'hFFF;
  localparam logic [11:0] L_H_TOTAL  = 12'(H_TOTAL);
  localparam logic [11:0] L_V_TOTAL  = 12'(V_TOTAL);
  localparam logic [11:0] L_H_ACT_LO = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] L_H_ACT_HI = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] L_V_ACT_LO = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] L_V_ACT_HI = 12'(V_SYNC + V_BACK + V_ACTIVE);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  logic        r_hs_q1, r_hs_q2, r_vs_q1, r_vs_q2;
  logic [11:0] r_h_cnt, r_v_cnt, r_line_len, r_frame_lines;
  logic        r_vs_pend, r_frame_start, r_line_chk;
  logic        r_active, r_locked, r_err, r_bad;
  state_t      r_state;

  logic        w_hs_fall, w_vs_fall, w_frame_qual, w_h_sat;
  logic [11:0] w_h_nxt, w_v_nxt;
  logic        w_h_in, w_v_in, w_sync_bad, w_bad_line, w_frame_ok;
  state_t      w_state_nxt;
  logic        w_bad_nxt, w_err_nxt, w_locked_nxt;

  assign w_hs_fall    = r_hs_q2 & ~r_hs_q1;
  assign w_vs_fall    = r_vs_q2 & ~r_vs_q1;
  assign w_frame_qual = w_hs_fall & (r_vs_pend | w_vs_fall);
  assign w_h_sat      = (r_h_cnt == L_CNT_MAX);

  // Two-stage input sampling; idles at the inactive (high) sync level
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_hs_q1 <= 1'b1;
      r_hs_q2 <= 1'b1;
      r_vs_q1 <= 1'b1;
      r_vs_q2 <= 1'b1;
    end else begin
      r_hs_q1 <= I_hs;
      r_hs_q2 <= r_hs_q1;
      r_vs_q1 <= I_vs;
      r_vs_q2 <= r_vs_q1;
    end
  end

  // Next coordinate values, shared by the counters and the active-video decode
  always_comb begin
    w_h_nxt = r_h_cnt;
    w_v_nxt = r_v_cnt;
    if (w_hs_fall) begin
      w_h_nxt = 12'd0;
    end else if (!w_h_sat) begin
      w_h_nxt = r_h_cnt + 12'd1;
    end else begin
      w_h_nxt = r_h_cnt;
    end
    if (w_frame_qual) begin
      w_v_nxt = 12'd0;
    end else if (w_hs_fall && (r_v_cnt != L_CNT_MAX)) begin
      w_v_nxt = r_v_cnt + 12'd1;
    end else begin
      w_v_nxt = r_v_cnt;
    end
  end

  // Coordinate counters and line/frame length capture
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_h_cnt       <= 12'd0;
      r_v_cnt       <= 12'd0;
      r_line_len    <= 12'd0;
      r_frame_lines <= 12'd0;
      r_vs_pend     <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_chk    <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_nxt;
      r_v_cnt       <= w_v_nxt;
      r_line_chk    <= w_hs_fall;
      r_frame_start <= w_frame_qual;
      if (w_hs_fall) begin
        r_line_len <= r_h_cnt + 12'd1;
      end
      if (w_frame_qual) begin
        r_frame_lines <= r_v_cnt + 12'd1;
      end
      // A vsync edge waits here until the next hsync edge opens the frame
      if (w_frame_qual) begin
        r_vs_pend <= 1'b0;
      end else if (w_vs_fall) begin
        r_vs_pend <= 1'b1;
      end
    end
  end

`ifdef VGA_SYNC_WIDTH_CHK_EN
  localparam logic [11:0] L_H_SYNC = 12'(H_SYNC);
  localparam logic [11:0] L_V_SYNC = 12'(V_SYNC);

  logic        w_hs_rise, w_vs_rise;
  logic [11:0] r_vs_lines;

  assign w_hs_rise = ~r_hs_q2 & r_hs_q1;
  assign w_vs_rise = ~r_vs_q2 & r_vs_q1;

  // Vsync low width in hsync edges; the frame-opening edge counts as the first
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_vs_lines <= 12'd0;
    end else if (w_frame_qual) begin
      r_vs_lines <= 12'd1;
    end else if (w_hs_fall && !r_vs_q1 && (r_vs_lines != L_CNT_MAX)) begin
      r_vs_lines <= r_vs_lines + 12'd1;
    end
  end

  // Hsync width reuses the line counter: it restarts at 0 on the falling edge
  assign w_sync_bad = (w_hs_rise && ((r_h_cnt + 12'd1) != L_H_SYNC)) ||
                      (w_vs_rise && (r_vs_lines != L_V_SYNC));
`else
  assign w_sync_bad = 1'b0;
`endif

  assign w_bad_line = (r_line_chk && (r_line_len != L_H_TOTAL)) || w_sync_bad;
  assign w_frame_ok = (r_frame_lines == L_V_TOTAL);

  // Lock FSM: next state, bad-line flag and error pulse
  always_comb begin
    w_state_nxt = r_state;
    w_bad_nxt   = r_bad;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        w_bad_nxt = 1'b0;
        if (r_frame_start) begin
          w_state_nxt = ST_MEASURE;
        end else begin
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_MEASURE: begin
        if (w_h_sat) begin
          w_state_nxt = ST_SEARCH;
          w_bad_nxt   = 1'b0;
        end else if (r_frame_start) begin
          // The line closing the frame is judged in the same cycle
          if (!r_bad && !w_bad_line && w_frame_ok) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_state_nxt = ST_MEASURE;
          end
          w_bad_nxt = 1'b0;
        end else if (w_bad_line) begin
          w_bad_nxt = 1'b1;
        end else begin
          w_bad_nxt = r_bad;
        end
      end
      ST_LOCKED: begin
        if (w_bad_line || (r_frame_start && !w_frame_ok) || w_h_sat) begin
          w_state_nxt = ST_SEARCH;
          w_err_nxt   = 1'b1;
          w_bad_nxt   = 1'b0;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_bad_nxt   = 1'b0;
      end
    endcase
  end

  assign w_locked_nxt = (w_state_nxt == ST_LOCKED);
  assign w_h_in       = (w_h_nxt >= L_H_ACT_LO) && (w_h_nxt < L_H_ACT_HI);
  assign w_v_in       = (w_v_nxt >= L_V_ACT_LO) && (w_v_nxt < L_V_ACT_HI);

  // FSM state and registered status outputs
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state  <= ST_SEARCH;
      r_bad    <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bad    <= w_bad_nxt;
      r_err    <= w_err_nxt;
      r_locked <= w_locked_nxt;
      r_active <= w_locked_nxt && w_h_in && w_v_in;
    end
  end

  assign O_h_cnt       = r_h_cnt;
  assign O_v_cnt       = r_v_cnt;
  assign O_active      = r_active;
  assign O_locked      = r_locked;
  assign O_frame_start = r_frame_start;
  assign O_err         = r_err;
  assign O_line_len    = r_line_len;
  assign O_frame_lines = r_frame_lines;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 32x20 timing so
// whole frames stay short; expectations are derived from the bench parameters.
module tb_vga_sync_decoder;

  localparam int HS = 4;
  localparam int HB = 4;
  localparam int HA = 16;
  localparam int HT = 32;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VA = 10;
  localparam int VT = 20;

  logic        I_clk;
  logic        I_rst_n;
  logic        I_hs;
  logic        I_vs;
  logic [11:0] O_h_cnt;
  logic [11:0] O_v_cnt;
  logic        O_active;
  logic        O_locked;
  logic        O_frame_start;
  logic        O_err;
  logic [11:0] O_line_len;
  logic [11:0] O_frame_lines;

  vga_sync_decoder #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .I_clk(I_clk),
    .I_rst_n(I_rst_n),
    .I_hs(I_hs),
    .I_vs(I_vs),
    .O_h_cnt(O_h_cnt),
    .O_v_cnt(O_v_cnt),
    .O_active(O_active),
    .O_locked(O_locked),
    .O_frame_start(O_frame_start),
    .O_err(O_err),
    .O_line_len(O_line_len),
    .O_frame_lines(O_frame_lines)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor state, sampled on the falling edge
  int          cyc = 0;
  int          fs_cnt = 0;
  int          err_cnt = 0;
  int          fs_last = 0;
  int          fs_prev = 0;
  int          lock_gap = -1;
  int          lock_span = -1;
  logic        lock_seen = 1'b0;
  logic        lk_prev = 1'b0;
  logic [11:0] pt_h [6];
  logic [11:0] pt_v [6];
  logic        pt_exp [6];
  logic        pt_seen [6];
  logic        pt_act [6];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_h_cnt"},       32'(O_h_cnt),       32'd0);
    check_val({tag, "_v_cnt"},       32'(O_v_cnt),       32'd0);
    check_val({tag, "_active"},      32'(O_active),      32'd0);
    check_val({tag, "_locked"},      32'(O_locked),      32'd0);
    check_val({tag, "_frame_start"}, 32'(O_frame_start), 32'd0);
    check_val({tag, "_err"},         32'(O_err),         32'd0);
    check_val({tag, "_line_len"},    32'(O_line_len),    32'd0);
    check_val({tag, "_frame_lines"}, 32'(O_frame_lines), 32'd0);
  endtask

  // One pixel per clock; pins change 1 ns after the rising edge
  task automatic send_lines(input int first, input int last, input int long_line, input int short_line);
    for (int ln = first; ln <= last; ln++) begin
      int len;
      int hsw;
      len = (ln == long_line) ? HT + 1 : HT;
      hsw = (ln == short_line) ? HS - 1 : HS;
      for (int px = 0; px < len; px++) begin
        I_hs = (px < hsw) ? 1'b0 : 1'b1;
        I_vs = (ln < VS) ? 1'b0 : 1'b1;
        @(posedge I_clk);
        #1;
      end
    end
  endtask

  task automatic send_frame(input int long_line, input int short_line);
    send_lines(0, VT - 1, long_line, short_line);
  endtask

  initial begin
    pt_h[0] = 12'(HS + HB);          pt_v[0] = 12'(VS + VB);          pt_exp[0] = 1'b1;
    pt_h[1] = 12'(HS + HB + HA - 1); pt_v[1] = 12'(VS + VB + VA - 1); pt_exp[1] = 1'b1;
    pt_h[2] = 12'(HS + HB - 1);      pt_v[2] = 12'(VS + VB);          pt_exp[2] = 1'b0;
    pt_h[3] = 12'(HS + HB + HA);     pt_v[3] = 12'(VS + VB);          pt_exp[3] = 1'b0;
    pt_h[4] = 12'(HS + HB);          pt_v[4] = 12'(VS + VB - 1);      pt_exp[4] = 1'b0;
    pt_h[5] = 12'(HS + HB);          pt_v[5] = 12'(VS + VB + VA);     pt_exp[5] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pt_seen[k] = 1'b0;
      pt_act[k]  = 1'b0;
    end
    forever begin
      @(negedge I_clk);
      cyc++;
      if (O_frame_start) begin
        fs_cnt++;
        fs_prev = fs_last;
        fs_last = cyc;
      end
      if (O_err) err_cnt++;
      if (O_locked && !lk_prev && !lock_seen) begin
        lock_seen = 1'b1;
        lock_gap  = cyc - fs_last;
        lock_span = cyc - fs_prev;
      end
      lk_prev = O_locked;
      if (O_locked) begin
        for (int k = 0; k < 6; k++) begin
          if (O_h_cnt == pt_h[k] && O_v_cnt == pt_v[k]) begin
            pt_seen[k] = 1'b1;
            pt_act[k]  = O_active;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_err;
    I_rst_n = 1'b0;
    I_hs    = 1'b1;
    I_vs    = 1'b1;
    repeat (3) @(posedge I_clk);
    #1;
    @(negedge I_clk);
    check_all_zero("rst");
    I_rst_n = 1'b1;
    @(posedge I_clk);
    #1;
    repeat (5) begin
      @(posedge I_clk);
      #1;
    end

    // Nominal stream: first frame measures, second frame_start locks
    send_frame(-1, -1);
    check_val("fs_first", 32'(fs_cnt), 32'd1);
    check_val("no_lock_first_frame", 32'(O_locked), 32'd0);
    send_frame(-1, -1);
    check_val("locked", 32'(O_locked), 32'd1);
    check_val("lock_gap", 32'(lock_gap), 32'd1);
    check_val("lock_span", 32'(lock_span), 32'(HT * VT + 1));
    check_val("frame_lines", 32'(O_frame_lines), 32'(VT));
    check_val("line_len", 32'(O_line_len), 32'(HT));
    check_val("err_nominal", 32'(err_cnt), 32'd0);
    for (int k = 0; k < 6; k++) begin
      check_val($sformatf("active_pt%0d", k), {30'd0, pt_seen[k], pt_act[k]}, {30'd0, 1'b1, pt_exp[k]});
    end

    // One line lengthened by a pixel
    send_frame(7, -1);
    check_val("long_err", 32'(err_cnt), 32'd1);
    check_val("long_unlock", 32'(O_locked), 32'd0);
    send_frame(-1, -1);
    check_val("long_measuring", 32'(O_locked), 32'd0);
    send_frame(-1, -1);
    check_val("long_relock", 32'(O_locked), 32'd1);
    check_val("long_err_once", 32'(err_cnt), 32'd1);

    // Hsync stuck high: counter saturation while locked
    I_hs = 1'b1;
    I_vs = 1'b1;
    repeat (5000) begin
      @(posedge I_clk);
      #1;
    end
    check_val("stuck_h_sat", 32'(O_h_cnt), 32'd4095);
    check_val("stuck_err", 32'(err_cnt), 32'd2);
    check_val("stuck_unlock", 32'(O_locked), 32'd0);
    send_frame(-1, -1);
    send_frame(-1, -1);
    check_val("stuck_relock", 32'(O_locked), 32'd1);

    // Hsync one pixel short on one line
    send_frame(-1, 3);
`ifdef VGA_SYNC_WIDTH_CHK_EN
    exp_err = 3;
    check_val("short_hs_err", 32'(err_cnt), 32'd3);
    check_val("short_hs_unlock", 32'(O_locked), 32'd0);
`else
    exp_err = 2;
    check_val("short_hs_no_err", 32'(err_cnt), 32'd2);
    check_val("short_hs_lock_held", 32'(O_locked), 32'd1);
`endif
    send_frame(-1, -1);
    send_frame(-1, -1);
    check_val("pre_reset_locked", 32'(O_locked), 32'd1);

    // Asynchronous reset in the middle of a frame
    send_lines(0, VT / 2 - 1, -1, -1);
    I_rst_n = 1'b0;
    @(negedge I_clk);
    check_all_zero("midrst");
    repeat (2) @(posedge I_clk);
    @(negedge I_clk);
    I_rst_n = 1'b1;
    @(posedge I_clk);
    #1;
    send_lines(VT / 2, VT - 1, -1, -1);
    check_val("post_rst_partial", 32'(O_locked), 32'd0);
    send_frame(-1, -1);
    check_val("post_rst_measuring", 32'(O_locked), 32'd0);
    send_frame(-1, -1);
    check_val("post_rst_relock", 32'(O_locked), 32'd1);
    check_val("final_err_cnt", 32'(err_cnt), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
